// File: rtl/player_pkg.sv
// player_pkg: shared state encoding, animation frame boundaries and sprite geometry.
package player_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    JUMP,
    ATTACK
  } state_t;

  // Animation counter landmarks (player_action / ball_action values)
  localparam logic [8:0] WALK_LAST  = 9'd23;
  localparam logic [8:0] JUMP_FIRST = 9'd24;
  localparam logic [8:0] RISE_LAST  = 9'd47;
  localparam logic [8:0] FALL_LAST  = 9'd71;
  localparam logic [8:0] JUMP_LAST  = 9'd89;
  localparam logic [8:0] ATK_FIRST  = 9'd90;
  localparam logic [8:0] ATK_SPAWN  = 9'd162;
  localparam logic [8:0] ATK_LAST   = 9'd185;
  localparam logic [8:0] BALL_LAST  = 9'd17;

  // Sprite geometry in pixels
  localparam logic [9:0] PLAYER_W   = 10'd80;
  localparam logic [9:0] BALL_W     = 10'd40;
  localparam logic [9:0] SCREEN_W   = 10'd640;
  localparam logic [9:0] BALL_X_MAX = SCREEN_W - BALL_W;
  localparam logic [9:0] BALL_Y_OFS = 10'd20;

  // Horizontal step with edge clamping; the comparison happens before the
  // subtraction/addition so the 10-bit position can never wrap around.
  function automatic logic [9:0] clamp_step(input logic [9:0] x,
                                            input logic [9:0] step,
                                            input logic       go_left,
                                            input logic [9:0] x_max);
    logic [10:0] sum;
    sum = {1'b0, x} + {1'b0, step};
    if (go_left) begin
      return (x < step) ? 10'd0 : (x - step);
    end
    return (sum > {1'b0, x_max}) ? x_max : sum[9:0];
  endfunction

endpackage

// File: rtl/fireball_ctrl.sv
// fireball_ctrl: fireball spawn, per-frame flight, animation counter and despawn.
module fireball_ctrl
  import player_pkg::*;
#(
  parameter logic [9:0] BALL_STEP = 10'd6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       tick_i,
  input  logic       spawn_i,
  input  logic       hit_i,
  input  logic [9:0] player_x_i,
  input  logic [9:0] player_y_i,
  input  logic       face_i,
  output logic       summoned_o,
  output logic [9:0] ball_x_o,
  output logic [9:0] ball_y_o,
  output logic       ball_face_o,
  output logic [8:0] ball_action_o
);

  logic       summoned_q, summoned_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       face_q, face_d;
  logic [8:0] action_q, action_d;
  logic       spawn_ok;
  logic       leaves_screen;

  // A ball spawned facing left starts 40 px left of the player, facing right it
  // starts at the player's right edge; either start must lie within 0..600.
  assign spawn_ok = face_i ? (player_x_i >= BALL_W)
                           : (({1'b0, player_x_i} + {1'b0, PLAYER_W}) <= {1'b0, BALL_X_MAX});

  assign leaves_screen = face_q ? (x_q < BALL_STEP)
                                : (({1'b0, x_q} + {1'b0, BALL_STEP}) > {1'b0, BALL_X_MAX});

  // Ball registers; a hit despawns on any Clk, flight only advances on frame ticks.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      summoned_q <= 1'b0;
      x_q        <= 10'd0;
      y_q        <= 10'd0;
      face_q     <= 1'b0;
      action_q   <= 9'd0;
    end else begin
      summoned_q <= summoned_d;
      x_q        <= x_d;
      y_q        <= y_d;
      face_q     <= face_d;
      action_q   <= action_d;
    end
  end

  // Next-state: spawn only from the inactive state, despawn wins over movement.
  always_comb begin
    summoned_d = summoned_q;
    x_d        = x_q;
    y_d        = y_q;
    face_d     = face_q;
    action_d   = action_q;
    if (!summoned_q) begin
      if (spawn_i && spawn_ok) begin
        summoned_d = 1'b1;
        face_d     = face_i;
        y_d        = player_y_i + BALL_Y_OFS;
        action_d   = 9'd0;
        x_d        = face_i ? (player_x_i - BALL_W) : (player_x_i + PLAYER_W);
      end
    end else if (hit_i) begin
      summoned_d = 1'b0;
      action_d   = 9'd0;
    end else if (tick_i) begin
      if (leaves_screen) begin
        summoned_d = 1'b0;
        action_d   = 9'd0;
      end else begin
        action_d = (action_q == BALL_LAST) ? 9'd0 : (action_q + 9'd1);
        x_d      = face_q ? (x_q - BALL_STEP) : (x_q + BALL_STEP);
      end
    end
  end

  assign summoned_o    = summoned_q;
  assign ball_x_o      = x_q;
  assign ball_y_o      = y_q;
  assign ball_face_o   = face_q;
  assign ball_action_o = action_q;

endmodule

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: per-player walk/jump/attack sequencer feeding the colour mapper.
module player_motion_ctrl
  import player_pkg::*;
#(
  parameter logic [9:0] START_X    = 10'd80,
  parameter logic       START_FACE = 1'b0,
  parameter logic [9:0] GROUND_Y   = 10'd300,
  parameter logic [9:0] X_MAX      = 10'd560,
  parameter logic [9:0] WALK_STEP  = 10'd2,
  parameter logic [9:0] JUMP_STEP  = 10'd4,
  parameter logic [9:0] BALL_STEP  = 10'd6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic       key_attack,
  input  logic       ball_hit,
  input  logic       ending,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic       face,
  output logic [8:0] player_action,
  output logic       summoned_ball,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_face,
  output logic [8:0] ball_action
);

  state_t     state_q, state_d;
  logic       frame_clk_q;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       face_q, face_d;
  logic [8:0] action_q, action_d;
  logic [8:0] action_inc;
  logic       tick;
  logic       hit;
  logic       one_dir;
  logic       spawn;

  // Game over freezes everything, so both the frame tick and the hit are masked.
  assign tick       = frame_clk & ~frame_clk_q & ~ending;
  assign hit        = ball_hit & ~ending;
  assign one_dir    = key_left ^ key_right;
  assign action_inc = action_q + 9'd1;
  assign spawn      = tick && (state_q == ATTACK) && (action_q == (ATK_SPAWN - 9'd1));

  // Frame-clock edge detector and the player state registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      frame_clk_q <= 1'b0;
      state_q     <= IDLE;
      x_q         <= START_X;
      y_q         <= GROUND_Y;
      face_q      <= START_FACE;
      action_q    <= 9'd0;
    end else begin
      frame_clk_q <= frame_clk;
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      face_q      <= face_d;
      action_q    <= action_d;
    end
  end

  // Per-tick FSM: attack beats jump beats walk; the jump arc is keyed on the new action value.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    face_d   = face_q;
    action_d = action_q;
    if (tick) begin
      case (state_q)
        IDLE, WALK: begin
          if (key_attack) begin
            state_d  = ATTACK;
            action_d = ATK_FIRST;
          end else if (key_jump) begin
            state_d  = JUMP;
            action_d = JUMP_FIRST;
            y_d      = y_q - JUMP_STEP;
          end else if (one_dir) begin
            state_d  = WALK;
            action_d = ((state_q == WALK) && (action_q != WALK_LAST)) ? action_inc : 9'd0;
            face_d   = key_left;
            x_d      = clamp_step(x_q, WALK_STEP, key_left, X_MAX);
          end else begin
            state_d  = IDLE;
            action_d = 9'd0;
          end
        end
        JUMP: begin
          if (one_dir) begin
            face_d = key_left;
            x_d    = clamp_step(x_q, WALK_STEP, key_left, X_MAX);
          end
          if (action_q == JUMP_LAST) begin
            state_d  = IDLE;
            action_d = 9'd0;
          end else begin
            action_d = action_inc;
            if (action_inc <= RISE_LAST) begin
              y_d = y_q - JUMP_STEP;
            end else if (action_inc <= FALL_LAST) begin
              y_d = y_q + JUMP_STEP;
            end else begin
              y_d = GROUND_Y;
            end
          end
        end
        ATTACK: begin
          if (action_q == ATK_LAST) begin
            state_d  = IDLE;
            action_d = 9'd0;
          end else begin
            action_d = action_inc;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  fireball_ctrl #(
    .BALL_STEP(BALL_STEP)
  ) u_fireball (
    .Clk          (Clk),
    .Reset        (Reset),
    .tick_i       (tick),
    .spawn_i      (spawn),
    .hit_i        (hit),
    .player_x_i   (x_q),
    .player_y_i   (y_q),
    .face_i       (face_q),
    .summoned_o   (summoned_ball),
    .ball_x_o     (ball_x),
    .ball_y_o     (ball_y),
    .ball_face_o  (ball_face),
    .ball_action_o(ball_action)
  );

  assign player_x      = x_q;
  assign player_y      = y_q;
  assign face          = face_q;
  assign player_action = action_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb_player_motion_ctrl: scoreboard bench for the player motion sequencer.
module tb_player_motion_ctrl;

  localparam int S_IDLE = 0;
  localparam int S_WALK = 1;
  localparam int S_JUMP = 2;
  localparam int S_ATK  = 3;

  localparam logic [60:0] RESET_VEC = {10'd80, 10'd300, 1'b0, 9'd0, 1'b0, 10'd0, 10'd0, 1'b0, 9'd0};

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic       key_left = 1'b0;
  logic       key_right = 1'b0;
  logic       key_jump = 1'b0;
  logic       key_attack = 1'b0;
  logic       ball_hit = 1'b0;
  logic       ending = 1'b0;
  logic [9:0] player_x, player_y, ball_x, ball_y;
  logic       face, summoned_ball, ball_face;
  logic [8:0] player_action, ball_action;
  logic [60:0] obsVec;

  int checks = 0;
  int failures = 0;

  // Reference model state, kept in plain integers
  int mX, mY, mAct, mState, mBx, mBy, mBact;
  bit mFace, mSum, mBface;

  logic [60:0] sb[$];
  logic [60:0] expVec;

  player_motion_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .key_left     (key_left),
    .key_right    (key_right),
    .key_jump     (key_jump),
    .key_attack   (key_attack),
    .ball_hit     (ball_hit),
    .ending       (ending),
    .player_x     (player_x),
    .player_y     (player_y),
    .face         (face),
    .player_action(player_action),
    .summoned_ball(summoned_ball),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .ball_face    (ball_face),
    .ball_action  (ball_action)
  );

  assign obsVec = {player_x, player_y, face, player_action, summoned_ball,
                   ball_x, ball_y, ball_face, ball_action};

  // 100 MHz-ish bench clock; only relative timing matters
  always #5 Clk = ~Clk;

  // Hard stop in case something wedges the sequence
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [60:0] model_vec();
    return {10'(mX), 10'(mY), mFace, 9'(mAct), mSum, 10'(mBx), 10'(mBy), mBface, 9'(mBact)};
  endfunction

  task automatic model_reset();
    mX = 80; mY = 300; mFace = 1'b0; mAct = 0; mState = S_IDLE;
    mSum = 1'b0; mBx = 0; mBy = 0; mBface = 1'b0; mBact = 0;
  endtask

  task automatic model_move(input bit l, input bit r);
    if (l != r) begin
      mFace = l;
      mX = l ? mX - 2 : mX + 2;
      if (mX < 0) mX = 0;
      if (mX > 560) mX = 560;
    end
  endtask

  // One frame of the reference behaviour (ball first, using the pre-tick player)
  task automatic model_tick(input bit l, input bit r, input bit j, input bit a);
    int nx;
    bit doSpawn;
    doSpawn = (mState == S_ATK) && (mAct == 161);
    if (mSum) begin
      nx = mBface ? mBx - 6 : mBx + 6;
      if (nx < 0 || nx > 600) begin
        mSum = 1'b0; mBact = 0;
      end else begin
        mBx = nx; mBact = (mBact + 1) % 18;
      end
    end else if (doSpawn) begin
      nx = mFace ? mX - 40 : mX + 80;
      if (nx >= 0 && nx <= 600) begin
        mSum = 1'b1; mBx = nx; mBy = mY + 20; mBface = mFace; mBact = 0;
      end
    end
    case (mState)
      S_IDLE, S_WALK: begin
        if (a) begin
          mState = S_ATK; mAct = 90;
        end else if (j) begin
          mState = S_JUMP; mAct = 24; mY = mY - 4;
        end else if (l != r) begin
          mAct = (mState == S_WALK) ? (mAct + 1) % 24 : 0;
          mState = S_WALK;
          model_move(l, r);
        end else begin
          mState = S_IDLE; mAct = 0;
        end
      end
      S_JUMP: begin
        model_move(l, r);
        if (mAct == 89) begin
          mState = S_IDLE; mAct = 0;
        end else begin
          mAct = mAct + 1;
          if (mAct <= 47) mY = mY - 4;
          else if (mAct <= 71) mY = mY + 4;
          else mY = 300;
        end
      end
      default: begin
        if (mAct == 185) begin
          mState = S_IDLE; mAct = 0;
        end else begin
          mAct = mAct + 1;
        end
      end
    endcase
  endtask

  // Drives one frame tick with the given keys and queues the model's expectation;
  // returns on the following falling edge when the outputs have settled.
  task automatic drive_tick(input bit l, input bit r, input bit j, input bit a, input bit e);
    @(negedge Clk);
    key_left = l; key_right = r; key_jump = j; key_attack = a; ending = e;
    frame_clk = 1'b1;
    if (!e) model_tick(l, r, j, a);
    sb.push_back(model_vec());
    @(posedge Clk);
    #1;
    @(negedge Clk);
    frame_clk = 1'b0;
    key_left = 1'b0; key_right = 1'b0; key_jump = 1'b0; key_attack = 1'b0; ending = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if (obsVec !== RESET_VEC) begin
      failures++;
      $display("[TB] FAIL reset_values: got %h want %h", obsVec, RESET_VEC);
    end
    model_reset();
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_walk();
    for (int i = 0; i < 30; i++) begin
      drive_tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      expVec = sb.pop_front();
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("[TB] FAIL walk_tick %0d: got %h want %h", i, obsVec, expVec);
      end
      checks++;
      if (player_action !== 9'(i % 24)) begin
        failures++;
        $display("[TB] FAIL walk_action %0d: got %0d want %0d", i, player_action, i % 24);
      end
    end
    checks++;
    if (player_x !== 10'd140 || face !== 1'b0) begin
      failures++;
      $display("[TB] FAIL walk_end: got x=%0d face=%0d want x=140 face=0", player_x, face);
    end
    drive_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expVec = sb.pop_front();
    checks++;
    if (obsVec !== expVec || player_action !== 9'd0) begin
      failures++;
      $display("[TB] FAIL walk_release: got %h want %h", obsVec, expVec);
    end
  endtask

  task automatic test_jump();
    drive_tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expVec = sb.pop_front();
    checks++;
    if (obsVec !== expVec) begin
      failures++;
      $display("[TB] FAIL jump_entry: got %h want %h", obsVec, expVec);
    end
    for (int i = 0; i < 70; i++) begin
      if (mState == S_IDLE) break;
      drive_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expVec = sb.pop_front();
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("[TB] FAIL jump_tick %0d: got %h want %h", i, obsVec, expVec);
      end
      if (mAct == 47) begin
        checks++;
        if (player_y !== 10'd204) begin
          failures++;
          $display("[TB] FAIL jump_apex: got y=%0d want 204", player_y);
        end
      end
      if (mAct == 72) begin
        checks++;
        if (player_y !== 10'd300) begin
          failures++;
          $display("[TB] FAIL jump_land: got y=%0d want 300", player_y);
        end
      end
    end
    checks++;
    if (player_action !== 9'd0 || player_y !== 10'd300 || mState != S_IDLE) begin
      failures++;
      $display("[TB] FAIL jump_exit: got action=%0d y=%0d want action=0 y=300", player_action, player_y);
    end
  endtask

  task automatic test_attack_spawn();
    // Reposition to x=100 facing right: 22 steps left, 2 right, then settle
    for (int i = 0; i < 25; i++) begin
      drive_tick(i < 22, (i >= 22) && (i < 24), 1'b0, 1'b0, 1'b0);
      expVec = sb.pop_front();
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("[TB] FAIL reposition_tick %0d: got %h want %h", i, obsVec, expVec);
      end
    end
    drive_tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expVec = sb.pop_front();
    checks++;
    if (obsVec !== expVec || player_action !== 9'd90) begin
      failures++;
      $display("[TB] FAIL attack_entry: got %h want %h", obsVec, expVec);
    end
    for (int i = 0; i < 80; i++) begin
      if (mAct == 162) break;
      drive_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expVec = sb.pop_front();
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("[TB] FAIL attack_tick %0d: got %h want %h", i, obsVec, expVec);
      end
    end
    checks++;
    if (summoned_ball !== 1'b1 || ball_x !== 10'd180 || ball_y !== 10'd320 || ball_action !== 9'd0) begin
      failures++;
      $display("[TB] FAIL spawn: got s=%0d bx=%0d by=%0d ba=%0d want 1 180 320 0",
               summoned_ball, ball_x, ball_y, ball_action);
    end
    drive_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expVec = sb.pop_front();
    checks++;
    if (obsVec !== expVec || ball_x !== 10'd186) begin
      failures++;
      $display("[TB] FAIL ball_move: got %h want %h", obsVec, expVec);
    end
  endtask

  task automatic test_ball_hit();
    // Hit pulse on a cycle with no frame tick
    @(negedge Clk);
    ball_hit = 1'b1;
    if (mSum) begin
      mSum = 1'b0; mBact = 0;
    end
    sb.push_back(model_vec());
    @(posedge Clk);
    #1;
    expVec = sb.pop_front();
    checks++;
    if (obsVec !== expVec || summoned_ball !== 1'b0 || ball_x !== 10'd186) begin
      failures++;
      $display("[TB] FAIL ball_hit: got %h want %h", obsVec, expVec);
    end
    @(negedge Clk);
    ball_hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mState == S_IDLE) break;
      drive_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expVec = sb.pop_front();
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("[TB] FAIL attack_finish %0d: got %h want %h", i, obsVec, expVec);
      end
    end
  endtask

  task automatic test_ball_edge();
    bit seen;
    seen = 1'b0;
    drive_tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expVec = sb.pop_front();
    checks++;
    if (obsVec !== expVec) begin
      failures++;
      $display("[TB] FAIL edge_entry: got %h want %h", obsVec, expVec);
    end
    for (int i = 0; i < 200; i++) begin
      drive_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expVec = sb.pop_front();
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("[TB] FAIL edge_tick %0d: got %h want %h", i, obsVec, expVec);
      end
      if (mSum) seen = 1'b1;
      if (seen && !mSum) break;
    end
    checks++;
    if (!seen || summoned_ball !== 1'b0 || ball_x !== 10'd600 || ball_action !== 9'd0) begin
      failures++;
      $display("[TB] FAIL edge_despawn: got s=%0d bx=%0d ba=%0d want 0 600 0",
               summoned_ball, ball_x, ball_action);
    end
  endtask

  task automatic test_left_clamp();
    for (int i = 0; i < 53; i++) begin
      drive_tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expVec = sb.pop_front();
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("[TB] FAIL left_tick %0d: got %h want %h", i, obsVec, expVec);
      end
    end
    checks++;
    if (player_x !== 10'd0 || face !== 1'b1) begin
      failures++;
      $display("[TB] FAIL left_clamp: got x=%0d face=%0d want x=0 face=1", player_x, face);
    end
    // Attack facing left at x=0 must not spawn a ball
    drive_tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expVec = sb.pop_front();
    checks++;
    if (obsVec !== expVec) begin
      failures++;
      $display("[TB] FAIL left_attack_entry: got %h want %h", obsVec, expVec);
    end
    for (int i = 0; i < 100; i++) begin
      if (mState == S_IDLE) break;
      drive_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expVec = sb.pop_front();
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("[TB] FAIL left_attack %0d: got %h want %h", i, obsVec, expVec);
      end
      if (mAct == 162) begin
        checks++;
        if (summoned_ball !== 1'b0) begin
          failures++;
          $display("[TB] FAIL left_nospawn: got s=%0d want 0", summoned_ball);
        end
      end
    end
  endtask

  task automatic test_right_clamp();
    for (int i = 0; i < 283; i++) begin
      drive_tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      expVec = sb.pop_front();
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("[TB] FAIL right_tick %0d: got %h want %h", i, obsVec, expVec);
      end
    end
    checks++;
    if (player_x !== 10'd560 || face !== 1'b0) begin
      failures++;
      $display("[TB] FAIL right_clamp: got x=%0d face=%0d want x=560 face=0", player_x, face);
    end
    drive_tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expVec = sb.pop_front();
    checks++;
    if (obsVec !== expVec) begin
      failures++;
      $display("[TB] FAIL right_attack_entry: got %h want %h", obsVec, expVec);
    end
    for (int i = 0; i < 100; i++) begin
      if (mState == S_IDLE) break;
      drive_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expVec = sb.pop_front();
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("[TB] FAIL right_attack %0d: got %h want %h", i, obsVec, expVec);
      end
      if (mAct == 162) begin
        checks++;
        if (summoned_ball !== 1'b0) begin
          failures++;
          $display("[TB] FAIL right_nospawn: got s=%0d want 0", summoned_ball);
        end
      end
    end
  endtask

  task automatic test_ending();
    // Jump entry plus five rising frames: action 29, y = 300 - 6*4 = 276
    for (int i = 0; i < 6; i++) begin
      drive_tick(1'b0, 1'b0, i == 0, 1'b0, 1'b0);
      expVec = sb.pop_front();
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("[TB] FAIL pre_ending %0d: got %h want %h", i, obsVec, expVec);
      end
    end
    for (int i = 0; i < 10; i++) begin
      drive_tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      expVec = sb.pop_front();
      checks++;
      if (obsVec !== expVec || player_action !== 9'd29 || player_y !== 10'd276) begin
        failures++;
        $display("[TB] FAIL ending_freeze %0d: got %h want %h", i, obsVec, expVec);
      end
    end
    for (int i = 0; i < 70; i++) begin
      if (mState == S_IDLE) break;
      drive_tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      expVec = sb.pop_front();
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("[TB] FAIL post_ending %0d: got %h want %h", i, obsVec, expVec);
      end
    end
  endtask

  task automatic test_reset_mid_jump();
    drive_tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expVec = sb.pop_front();
    checks++;
    if (obsVec !== expVec) begin
      failures++;
      $display("[TB] FAIL rst_jump_entry: got %h want %h", obsVec, expVec);
    end
    for (int i = 0; i < 30; i++) begin
      if (mAct == 40) break;
      drive_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expVec = sb.pop_front();
      checks++;
      if (obsVec !== expVec) begin
        failures++;
        $display("[TB] FAIL rst_jump_tick %0d: got %h want %h", i, obsVec, expVec);
      end
    end
    checks++;
    if (player_action !== 9'd40 || player_y !== 10'd232) begin
      failures++;
      $display("[TB] FAIL rst_mid_jump: got action=%0d y=%0d want 40 232", player_action, player_y);
    end
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    checks++;
    if (obsVec !== RESET_VEC) begin
      failures++;
      $display("[TB] FAIL async_reset: got %h want %h", obsVec, RESET_VEC);
    end
    model_reset();
    @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expVec = sb.pop_front();
      checks++;
      if (obsVec !== expVec || player_action !== 9'd0 || player_y !== 10'd300) begin
        failures++;
        $display("[TB] FAIL post_reset_idle %0d: got %h want %h", i, obsVec, expVec);
      end
    end
  endtask

  // Scenario sequence
  initial begin
    $display("[TB] starting player_motion_ctrl bench");
    test_reset();
    test_walk();
    test_jump();
    test_attack_spawn();
    test_ball_hit();
    test_ball_edge();
    test_left_clamp();
    test_right_clamp();
    test_ending();
    test_reset_mid_jump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
